cv32e40p_tb_obi_initiator: RTL and testbench

//  Bench-side OBI data-port initiator: drives the same req/gnt/rvalid memory interface the core data port drives.

---
 rtl/cv32e40p_tb_obi_initiator.sv | 111 +++++++++++
 tb/tb_cv32e40p_tb_obi_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tb_obi_initiator.sv
// cv32e40p_tb_obi_initiator: cmd/rsp stream to OBI data-port initiator with in-order responses
module cv32e40p_tb_obi_initiator #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_we_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_we_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          occ, t_cnt, r_cnt;
    logic [PW-1:0]          t_wr, t_rd, r_wr, r_rd;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [DATA_WIDTH:0]    rsp_mem [MAX_OUTSTANDING];
    logic                   accept, grant, t_pop, rsp_hs;

    // pointers wrap at the FIFO depth, which need not be a power of two
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == LAST ? '0 : p + 1'b1;
    endfunction

    assign data_req_o  = state == REQ;
    assign cmd_ready_o = occ < MAX_C && (!data_req_o || data_gnt_i);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign grant       = data_req_o && data_gnt_i;
    assign t_pop       = data_rvalid_i && t_cnt != '0;
    assign rsp_valid_o = r_cnt != '0;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;
    assign {rsp_we_o, rsp_rdata_o} = rsp_valid_o ? rsp_mem[r_rd] : '0;
    assign busy_o      = occ != '0;

    // a new accept always (re)loads the request; a grant alone retires it
    always_comb begin
        state_n = accept ? REQ : grant ? IDLE : state;
    end

    // request stage: state and the held OBI request fields
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            data_addr_o  <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                data_addr_o  <= cmd_addr_i;
                data_we_o    <= cmd_we_i;
                data_be_o    <= cmd_be_i;
                data_wdata_o <= cmd_wdata_i;
            end
        end
    end

    // credit counter, tag/response FIFO bookkeeping and sticky error on an unexpected rvalid
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ   <= '0;
            t_cnt <= '0;
            r_cnt <= '0;
            t_wr  <= '0;
            t_rd  <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            err_o <= 1'b0;
        end else begin
            occ   <= occ + CW'(accept) - CW'(rsp_hs);
            t_cnt <= t_cnt + CW'(grant) - CW'(t_pop);
            r_cnt <= r_cnt + CW'(t_pop) - CW'(rsp_hs);
            if (grant) t_wr <= inc(t_wr);
            if (t_pop) t_rd <= inc(t_rd);
            if (t_pop) r_wr <= inc(r_wr);
            if (rsp_hs) r_rd <= inc(r_rd);
            err_o <= err_o | (data_rvalid_i && t_cnt == '0);
        end
    end

    // FIFO storage; contents are only observed through the counted entries
    always_ff @(posedge clk_i) begin
        if (grant) tag_mem[t_wr] <= data_we_o;
        if (t_pop) rsp_mem[r_wr] <= {tag_mem[t_rd], tag_mem[t_rd] ? {DATA_WIDTH{1'b0}} : data_rdata_i};
    end
endmodule

// File: tb/tb_cv32e40p_tb_obi_initiator.sv
// tb_cv32e40p_tb_obi_initiator: directed and randomized checks of the OBI initiator against a queue model
module tb_cv32e40p_tb_obi_initiator;
    localparam int MAX = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } txn_t;

    logic        clk = 1'b0, rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_we_o;
    logic [31:0] rsp_rdata_o;
    logic        data_req_o, data_gnt_i = 1'b0, data_we_o, data_rvalid_i = 1'b0;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0;
    logic [3:0]  data_be_o;
    logic        busy_o, err_o;

    txn_t        pend_q[$], infl_q[$], slave_q[$];
    logic [32:0] rbuf_q[$];
    logic [31:0] ref_mem[int], slv_mem[int];
    int          total = 0, bad = 0, n_acc = 0;
    bit          err_m = 1'b0, chk_en = 1'b0, dir_mode = 1'b1;

    always #5 clk = ~clk;

    cv32e40p_tb_obi_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_we_o(rsp_we_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .busy_o(busy_o), .err_o(err_o)
    );

    function automatic int occ();
        return pend_q.size() + infl_q.size() + rbuf_q.size();
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
    endfunction

    function automatic logic [31:0] slv_rd(input int i);
        return slv_mem.exists(i) ? slv_mem[i] : init_word(i);
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // every cycle: DUT outputs against the queue model
    always @(negedge clk) begin
        if (chk_en && !rst_i) begin
            chk("cmd_ready", cmd_ready_o, occ() < MAX && (pend_q.size() == 0 || data_gnt_i));
            chk("occ_bound", occ() <= MAX, 1);
            chk("data_req", data_req_o, pend_q.size() != 0);
            if (pend_q.size() != 0) begin
                chk("data_addr", data_addr_o, pend_q[0].addr);
                chk("data_ctl", {data_we_o, data_be_o}, {pend_q[0].we, pend_q[0].be});
                chk("data_wdata", data_wdata_o, pend_q[0].wdata);
            end
            chk("rsp_valid", rsp_valid_o, rbuf_q.size() != 0);
            if (rbuf_q.size() != 0) chk("rsp_data", {rsp_we_o, rsp_rdata_o}, rbuf_q[0]);
            chk("busy", busy_o, occ() != 0);
            chk("err", err_o, err_m);
        end
    end

    task automatic tick();
        bit acc, gnt_e, rv, hs;
        txn_t c, bus, t;
        logic [31:0] rvd;
        int idx;
        #1;
        acc   = cmd_valid_i && cmd_ready_o;
        gnt_e = pend_q.size() != 0 && data_gnt_i;
        rv    = data_rvalid_i;
        rvd   = data_rdata_i;
        hs    = rbuf_q.size() != 0 && rsp_ready_i;
        bus   = {data_addr_o, data_we_o, data_be_o, data_wdata_o, 32'h0};
        c     = {cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i, 32'h0};
        @(posedge clk);
        #1;
        if (hs) void'(rbuf_q.pop_front());
        if (rv) begin
            if (infl_q.size() == 0) err_m = 1'b1;
            else begin
                t = infl_q.pop_front();
                rbuf_q.push_back({t.we, t.we ? 32'h0 : (dir_mode ? rvd : t.exp)});
            end
        end
        if (gnt_e) begin
            infl_q.push_back(pend_q.pop_front());
            slave_q.push_back(bus);
        end
        if (acc) begin
            idx = int'(c.addr >> 2);
            if (c.we) ref_mem[idx] = merge(ref_rd(idx), c.wdata, c.be);
            else c.exp = ref_rd(idx);
            pend_q.push_back(c);
            n_acc++;
        end
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        {cmd_valid_i, cmd_we_i, data_gnt_i, data_rvalid_i, rsp_ready_i} = '0;
        cmd_addr_i = '0; cmd_be_i = '0; cmd_wdata_i = '0; data_rdata_i = '0;
        @(posedge clk);
        #1;
        pend_q.delete(); infl_q.delete(); rbuf_q.delete(); slave_q.delete();
        err_m = 1'b0;
        rst_i = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_be_i = be; cmd_wdata_i = wd;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_flags"}, {cmd_ready_o, rsp_valid_o, rsp_we_o, data_req_o, data_we_o, busy_o, err_o}, 7'b1000000);
        chk({nm, "_bus"}, {data_addr_o, data_be_o, data_wdata_o}, 0);
        chk({nm, "_rdata"}, rsp_rdata_o, 0);
    endtask

    task automatic rnd_drive(input bit allow_cmd);
        txn_t s;
        int idx;
        cmd_valid_i = allow_cmd && ($urandom % 10 < 6);
        cmd_we_i    = 1'($urandom % 2);
        cmd_addr_i  = 32'($urandom_range(0, 15)) << 2;
        cmd_be_i    = 4'($urandom_range(1, 15));
        cmd_wdata_i = $urandom;
        data_gnt_i  = $urandom % 10 < 7;
        rsp_ready_i = $urandom % 10 < 7;
        if (slave_q.size() != 0 && $urandom % 10 < 6) begin
            s = slave_q.pop_front();
            idx = int'(s.addr >> 2);
            data_rvalid_i = 1'b1;
            if (s.we) begin
                slv_mem[idx] = merge(slv_rd(idx), s.wdata, s.be);
                data_rdata_i = $urandom;
            end else data_rdata_i = slv_rd(idx);
        end else begin
            data_rvalid_i = 1'b0;
            data_rdata_i = $urandom;
        end
    endtask

    initial begin
        reset_dut();
        chk_zero("reset");
        // single read
        set_cmd(32'h100, 1'b0, 4'hF, 32'h0); rsp_ready_i = 1'b1;
        #1 chk("t1_ready", cmd_ready_o, 1);
        tick();
        chk("t1_req", {data_req_o, data_addr_o}, {1'b1, 32'h100});
        cmd_valid_i = 1'b0; data_gnt_i = 1'b1;
        tick();
        chk("t1_req_low", {data_req_o, rsp_valid_o}, 2'b00);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
        tick();
        chk("t1_rsp", {rsp_valid_o, rsp_we_o, rsp_rdata_o, busy_o}, {2'b10, 32'hDEADBEEF, 1'b1});
        data_rvalid_i = 1'b0;
        tick();
        chk("t1_idle", {busy_o, rsp_valid_o}, 2'b00);
        // write with delayed grant
        reset_dut();
        set_cmd(32'h104, 1'b1, 4'b0011, 32'h12345678); rsp_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold", {data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o},
                {1'b1, 32'h104, 1'b1, 4'b0011, 32'h12345678});
            data_gnt_i = i == 3;
            tick();
        end
        chk("t2_req_low", data_req_o, 0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
        tick();
        data_rvalid_i = 1'b0;
        chk("t2_rsp", {rsp_valid_o, rsp_we_o, rsp_rdata_o}, {2'b11, 32'h0});
        tick();
        chk("t2_idle", busy_o, 0);
        // credit limit
        reset_dut();
        data_gnt_i = 1'b1;
        set_cmd(32'h200, 1'b0, 4'hF, 32'h0);
        #1 chk("t3_ready_a", cmd_ready_o, 1);
        tick();
        cmd_addr_i = 32'h204;
        #1 chk("t3_ready_b", cmd_ready_o, 1);
        tick();
        cmd_addr_i = 32'h208; data_rvalid_i = 1'b1; data_rdata_i = 32'h1;
        #1 chk("t3_ready_c", cmd_ready_o, 0);
        tick();
        data_rdata_i = 32'h2; rsp_ready_i = 1'b1;
        #1 chk("t3_ready_d", {cmd_ready_o, rsp_valid_o, rsp_rdata_o}, {2'b01, 32'h1});
        tick();
        data_rvalid_i = 1'b0;
        #1 chk("t3_ready_e", {cmd_ready_o, rsp_valid_o, rsp_rdata_o}, {2'b11, 32'h2});
        tick();
        cmd_valid_i = 1'b0;
        chk("t3_third", {data_req_o, data_addr_o}, {1'b1, 32'h208});
        // response backpressure
        reset_dut();
        data_gnt_i = 1'b1;
        set_cmd(32'h300, 1'b0, 4'hF, 32'h0);
        tick();
        cmd_addr_i = 32'h304;
        tick();
        cmd_valid_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hA;
        tick();
        data_rdata_i = 32'hB;
        tick();
        data_rvalid_i = 1'b0;
        chk("t4_head", {rsp_valid_o, rsp_rdata_o}, {1'b1, 32'hA});
        tick();
        chk("t4_held", {rsp_valid_o, rsp_rdata_o}, {1'b1, 32'hA});
        rsp_ready_i = 1'b1;
        tick();
        chk("t4_second", {rsp_valid_o, rsp_rdata_o}, {1'b1, 32'hB});
        tick();
        chk("t4_drained", {rsp_valid_o, busy_o}, 2'b00);
        // stray rvalid and rvalid that outlives a reset
        reset_dut();
        data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        chk("t5_stray", err_o, 1);
        tick();
        chk("t5_sticky", err_o, 1);
        reset_dut();
        chk("t5_cleared", err_o, 0);
        set_cmd(32'h400, 1'b0, 4'hF, 32'h0);
        tick();
        cmd_valid_i = 1'b0; data_gnt_i = 1'b1;
        tick();
        reset_dut();
        chk("t5_busy_rst", busy_o, 0);
        data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        chk("t5_late", err_o, 1);
        reset_dut();
        chk_zero("t5_fresh");
        // randomized traffic against the reference memory
        dir_mode = 1'b0;
        reset_dut();
        ref_mem.delete(); slv_mem.delete();
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
            rnd_drive(1'b1);
            tick();
        end
        chk("rand_cmds", n_acc, 1000);
        for (int c = 0; c < 2000 && occ() != 0; c++) begin
            rnd_drive(1'b0);
            tick();
        end
        {data_rvalid_i, data_gnt_i, rsp_ready_i} = '0;
        chk("rand_drain", occ(), 0);
        chk("rand_final", {busy_o, err_o, rsp_valid_o}, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
